// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  // Request as captured on the accept edge; later input changes are ignored.
  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [WORD_BYTES-1:0] be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage split into byte lanes: synchronous byte-enabled write, asynchronous read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    logic [7:0] lane [DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane[addr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with LATENCY wait states between accept and response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  dmem_state_t state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  dmem_req_t   req_reg, req_next;
  logic        ready_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic        addr_err;
  logic        access;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign addr_err = (req_reg.addr[ADDR_LSB-1:0] != '0) ||
                    (req_reg.addr[31:ADDR_LSB] >= DEPTH_W);
  assign access   = (state_reg == WAIT) && (cnt_reg == '0);
  // Errored stores must never reach the array, even though the low index bits alias a valid word.
  assign mem_we   = access && req_reg.we && !addr_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (req_reg.be),
    .addr  (req_reg.addr[IDX_W+ADDR_LSB-1:ADDR_LSB]),
    .wdata (req_reg.wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && ready_reg) begin
          req_next   = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
          cnt_next   = CNT_INIT;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          rdata_next = (!req_reg.we && !addr_err) ? mem_rdata : '0;
          err_next   = addr_err;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ready is registered so it stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      req_reg   <= '0;
      ready_reg <= 1'b0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
      ready_reg <= (state_next == IDLE);
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances at LATENCY 2, 1 and 15 sharing clock and reset.
module tb_dmem_responder;

  localparam int NDUT = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_we    [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_be    [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_accept = 0;
  sb_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    dmem_responder #(
      .DEPTH   (64),
      .LATENCY (gi == 0 ? 2 : (gi == 1 ? 1 : 15))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready[gi]),
      .req_we    (req_we[gi]),
      .req_addr  (req_addr[gi]),
      .req_wdata (req_wdata[gi]),
      .req_be    (req_be[gi]),
      .rsp_valid (rsp_valid[gi]),
      .rsp_ready (rsp_ready[gi]),
      .rsp_rdata (rsp_rdata[gi]),
      .rsp_err   (rsp_err[gi])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  // Drives one request, pushes its expectation on accept, pops and compares on response.
  task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    int  n;
    int  lat;
    sb_t e;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be; rsp_ready[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout dut%0d addr=%0d: req_ready=%b, required 1", d, addr, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_accept = cyc;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    // Scramble the request bus to show nothing is resampled after the accept edge.
    req_valid[d] = 1'b0; req_we[d] = ~we; req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
    while (!rsp_valid[d] && (cyc - last_accept) < 40) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - last_accept;
    e = sb.pop_front();
    checks++;
    if (rsp_valid[d] !== 1'b1 || lat != lat_of(d)) begin
      errors++;
      $display("FAIL latency dut%0d addr=%0d: got %0d cycles (valid=%b), required %0d",
               d, addr, lat, rsp_valid[d], lat_of(d));
    end
    checks++;
    if (rsp_rdata[d] !== e.rdata) begin
      errors++;
      $display("FAIL rdata dut%0d addr=%0d: got %h, required %h", d, addr, rsp_rdata[d], e.rdata);
    end
    checks++;
    if (rsp_err[d] !== e.err) begin
      errors++;
      $display("FAIL err dut%0d addr=%0d: got %b, required %b", d, addr, rsp_err[d], e.err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL rsp_drop dut%0d: rsp_valid=%b after handshake, required 0", d, rsp_valid[d]);
    end
    $display("txn dut%0d we=%b addr=%0d be=%h rdata=%h err=%b lat=%0d",
             d, we, addr, be, rsp_rdata[d], rsp_err[d], lat);
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b1;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready[0], rsp_valid[0], rsp_err[0]} !== 3'b000 || rsp_rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h, required all 0",
               req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready dut%0d: got %b, required 1", d, req_ready[d]);
      end
    end
    $display("reset done");
  endtask

  task automatic test_store_load();
    txn(0, 1'b1, 32'd104, 32'd25, 4'hF, 32'h0, 1'b0);
    txn(0, 1'b0, 32'd104, 32'h0, 4'h0, 32'd25, 1'b0);
  endtask

  task automatic test_byte_enable();
    txn(0, 1'b1, 32'd96, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0);
    txn(0, 1'b1, 32'd96, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    txn(0, 1'b0, 32'd96, 32'h0, 4'hF, 32'hAA22CC44, 1'b0);
    txn(0, 1'b1, 32'd96, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    txn(0, 1'b0, 32'd96, 32'h0, 4'h0, 32'hAA22CC44, 1'b0);
  endtask

  task automatic test_errors();
    txn(0, 1'b1, 32'd44, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0);
    txn(0, 1'b1, 32'd252, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    txn(0, 1'b0, 32'd252, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);
    txn(0, 1'b0, 32'd256, 32'h0, 4'hF, 32'h0, 1'b1);
    txn(0, 1'b0, 32'd98, 32'h0, 4'hF, 32'h0, 1'b1);
    // Word 75 aliases word 11 (byte 44) in the low index bits.
    txn(0, 1'b1, 32'd300, 32'h0BAD0BAD, 4'hF, 32'h0, 1'b1);
    txn(0, 1'b1, 32'd46, 32'h0BAD0BAD, 4'hF, 32'h0, 1'b1);
    txn(0, 1'b0, 32'd44, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b0);
  endtask

  task automatic test_backpressure();
    int  n;
    int  acc;
    sb_t e;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'd96; req_be[0] = 4'hF; rsp_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back('{rdata: 32'hAA22CC44, err: 1'b0});
    @(negedge clk);
    req_addr[0] = 32'd104;
    n = 0;
    while (!rsp_valid[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err) begin
      errors++;
      $display("FAIL bp_first_rsp: valid=%b rdata=%h err=%b, required 1 %h %b",
               rsp_valid[0], rsp_rdata[0], rsp_err[0], e.rdata, e.err);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err ||
          req_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                 i, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0], e.rdata, e.err);
      end
    end
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0 1", rsp_valid[0], req_ready[0]);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    checks++;
    if (req_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: ready=%b, required 0 after accept", req_ready[0]);
    end
    sb.push_back('{rdata: 32'd25, err: 1'b0});
    @(negedge clk);
    req_valid[0] = 1'b0;
    while (!rsp_valid[0] && (cyc - acc) < 40) begin
      @(posedge clk);
      #1;
    end
    e = sb.pop_front();
    checks++;
    if (rsp_valid[0] !== 1'b1 || (cyc - acc) != 2 || rsp_rdata[0] !== e.rdata) begin
      errors++;
      $display("FAIL bp_second_rsp: valid=%b lat=%0d rdata=%h, required 1 2 %h",
               rsp_valid[0], cyc - acc, rsp_rdata[0], e.rdata);
    end
    @(posedge clk);
    #1;
    $display("backpressure done rdata=%h", rsp_rdata[0]);
  endtask

  task automatic test_back_to_back();
    int a0;
    txn(0, 1'b0, 32'd104, 32'h0, 4'hF, 32'd25, 1'b0);
    for (int i = 0; i < 2; i++) begin
      a0 = last_accept;
      txn(0, 1'b0, 32'd104, 32'h0, 4'hF, 32'd25, 1'b0);
      checks++;
      if (last_accept - a0 != lat_of(0) + 2) begin
        errors++;
        $display("FAIL back_to_back spacing: got %0d cycles, required %0d", last_accept - a0, lat_of(0) + 2);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    txn(0, 1'b1, 32'd100, 32'h12345678, 4'hF, 32'h0, 1'b0);
    txn(0, 1'b0, 32'd100, 32'h0, 4'hF, 32'h12345678, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'd100;
    req_wdata[0] = 32'hDEADBEEF; req_be[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({req_ready[0], rsp_valid[0], rsp_err[0]} !== 3'b000 || rsp_rdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_outputs: ready=%b valid=%b err=%b rdata=%h, required all 0",
               req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL discarded_rsp cycle %0d: rsp_valid=%b, required 0", i, rsp_valid[0]);
      end
    end
    txn(0, 1'b0, 32'd100, 32'h0, 4'hF, 32'h12345678, 1'b0);
  endtask

  task automatic test_latency_builds();
    logic [31:0] a;
    logic [31:0] w;
    for (int d = 1; d < NDUT; d++) begin
      for (int i = 0; i < 20; i++) begin
        a = 32'($urandom_range(0, 63)) << 2;
        w = $urandom;
        txn(d, 1'b1, a, w, 4'hF, 32'h0, 1'b0);
        txn(d, 1'b0, a, 32'h0, 4'($urandom), w, 1'b0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_latency_builds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
